axis_pkt_arbiter: RTL and testbench
===================================

Name: axis_pkt_arbiter

Overview:
Packet-atomic round-robin arbiter that merges NUM_PORTS AXI-Stream sources into one stream feeding the write side of the async CDC FIFO. A grant is held from first beat to TLAST, so packets are never interleaved. New packets start only while the downstream FIFO reports room (fifo_almost_full low). Per-port enables let software quiesce individual sources.

Parameters:
NUM_PORTS, 4, number of input streams (>=2)
DATA_WIDTH, 64, TDATA width per port
KEEP_WIDTH, DATA_WIDTH/8, TKEEP width per port
USER_WIDTH, 72, TUSER width per port
ID_WIDTH (localparam), $clog2(NUM_PORTS), source-ID width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i at slice [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port TKEEP, same slicing
s_axis_tlast  in  NUM_PORTS  per-port TLAST
s_axis_tuser  in  NUM_PORTS*USER_WIDTH  per-port TUSER
s_axis_tvalid  in  NUM_PORTS  per-port TVALID
s_axis_tready  out  NUM_PORTS  per-port TREADY
m_axis_tdata  out  DATA_WIDTH  merged TDATA (registered)
m_axis_tkeep  out  KEEP_WIDTH  merged TKEEP
m_axis_tlast  out  1  merged TLAST
m_axis_tuser  out  USER_WIDTH  merged TUSER
m_axis_tid  out  ID_WIDTH  source port of current beat
m_axis_tvalid  out  1  merged TVALID
m_axis_tready  in  1  downstream ready (FIFO s_axis_tready)
fifo_almost_full  in  1  FIFO wr_almost_full; blocks new packet starts
cfg_port_en  in  NUM_PORTS  per-port arbitration enable
busy  out  1  high while a packet is in flight (state PKT)
cur_grant  out  ID_WIDTH  currently or last granted port

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; m_axis_tvalid=0; m_axis_tdata/tkeep/tlast/tuser/tid=0; s_axis_tready=0; busy=0; cur_grant=0.
- FSM states: IDLE, PKT.
- IDLE: req = s_axis_tvalid & cfg_port_en. If fifo_almost_full=0 and req!=0, grant = first set bit of req, searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS. Register grant into cur_grant, go to PKT. No s_axis_tready is asserted while in IDLE.
- PKT: out_free = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready[cur_grant] = out_free. All other tready bits = 0.
  - On beat transfer: load the output register with the port's data, keep, last, user and tid=cur_grant, and set m_axis_tvalid=1.
  - If the transferred beat has tlast=1: state goes to IDLE and rr_ptr = (cur_grant+1) mod NUM_PORTS, with explicit wrap (not a power-of-2 mask).
- Output register: m_axis_tvalid clears when m_axis_tready=1 and no new beat is loaded that cycle. The output is stable while m_axis_tvalid=1 and m_axis_tready=0.
- Throughput and latency:
  - One beat per clock within a packet.
  - One IDLE arbitration cycle between packets.
  - First beat appears on m_axis two cycles after its tvalid is sampled in IDLE.
- fifo_almost_full only gates entry into PKT. A packet already in flight completes, relying on FIFO headroom.
- Deasserting cfg_port_en[cur_grant] mid-packet does not abort; the packet finishes and the port is skipped thereafter.
- A source dropping tvalid mid-packet keeps the grant held (no timeout). The arbiter waits in PKT.
- A port that asserts tvalid while another is granted sees tready=0 and waits for round-robin.
- All masks, with fifo_almost_full=1 or req=0: stay in IDLE; cur_grant holds.
- busy = (state==PKT).

Optional Feature:
AXIS_ARB_STATS_EN
- Defined: adds outputs stat_pkt_cnt (NUM_PORTS*32, per-port completed-packet counts, +1 on each tlast transfer) and stat_stall_cnt (32, cycles in IDLE with req!=0 and fifo_almost_full=1). Counters reset to 0, wrap at 2^32, and are cleared synchronously by input stat_clr (1 bit, this cycle's increment is lost).
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset mid-packet (port 2 granted, beat 3 of 5) -> all outputs 0, state IDLE, rr_ptr=0. Next grant goes to the lowest enabled requester.
- All 4 ports with 3-beat packets, continuous valid, m_axis_tready=1 -> grant order 0,1,2,3,0. Output tid sequence is 0,0,0,1,1,1,... with exactly one idle cycle between packets and no interleaving.
- Port 1 mid-packet, fifo_almost_full rises -> port 1 packet completes. Port 3 (pending) is not granted until fifo_almost_full=0, then starts within 2 cycles.
- m_axis_tready toggling 1,0,0,1 during an 8-beat packet -> no beat lost or duplicated. Output data is held stable while stalled, and tlast appears on the 8th output beat only.
- cfg_port_en=4'b1010 with all ports valid -> only ports 1 and 3 are granted, alternating. Clearing bit 1 mid-packet lets that packet finish, then only port 3 is granted.
- With AXIS_ARB_STATS_EN: 5 packets from port 0, 2 from port 3 -> stat_pkt_cnt = {2,0,0,5}. A stat_clr pulse zeroes all counts.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_pkt_arbiter
//
// Packet-atomic round-robin arbiter. It merges NUM_PORTS AXI-Stream sources
// into one registered stream that feeds the write side of an async CDC FIFO.
// A grant is held from the first beat of a packet to its TLAST, so packets
// are never interleaved. New packets start only while the FIFO reports room
// (fifo_almost_full low). Per-port enables let software quiesce sources.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              NUM_PORTS slave streams; port i at slice [i*W +: W]
//   s_axis_tready         per-port ready, only the granted port may see 1
//   m_axis_*              merged master stream, all payload fields registered
//   m_axis_tid            source port of the beat on m_axis
//   fifo_almost_full      blocks new packet starts (not packets in flight)
//   cfg_port_en           per-port arbitration enable
//   busy                  high while a packet is in flight
//   cur_grant             currently or last granted port
//
// Optional build macro:
//   AXIS_ARB_STATS_EN     adds stat_clr input plus stat_pkt_cnt (per-port
//                         completed packets) and stat_stall_cnt (IDLE cycles
//                         with requests blocked by fifo_almost_full).
// -----------------------------------------------------------------------------
module axis_pkt_arbiter #(
  parameter int  NUM_PORTS  = 4,
  parameter int  DATA_WIDTH = 64,
  parameter int  KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int  USER_WIDTH = 72,
  localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  input  logic                             fifo_almost_full,
  input  logic [NUM_PORTS-1:0]             cfg_port_en,
  output logic                             busy,
`ifdef AXIS_ARB_STATS_EN
  input  logic                             stat_clr,
  output logic [NUM_PORTS*32-1:0]          stat_pkt_cnt,
  output logic [31:0]                      stat_stall_cnt,
`endif
  output logic [ID_WIDTH-1:0]              cur_grant
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  localparam logic [ID_WIDTH-1:0] ID_ZERO   = {ID_WIDTH{1'b0}};
  localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

  // Successor port with an explicit wrap so non-power-of-two counts work.
  function automatic logic [ID_WIDTH-1:0] next_port(input logic [ID_WIDTH-1:0] p);
    logic [ID_WIDTH-1:0] r;
    if (p == LAST_PORT) begin
      r = ID_ZERO;
    end else begin
      r = p + ID_WIDTH'(1'b1);
    end
    return r;
  endfunction

  // Round-robin search starting at ptr; returns {found, port}.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [ID_WIDTH-1:0]  ptr);
    logic                found;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] pick;
    found = 1'b0;
    pick  = ID_ZERO;
    cand  = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end else begin
        pick  = pick;
      end
      cand = next_port(cand);
    end
    return {found, pick};
  endfunction

  state_e                   state_q, state_d;
  logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]      cur_grant_q, cur_grant_d;
  logic                     m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0]    m_keep_q, m_keep_d;
  logic                     m_last_q, m_last_d;
  logic [USER_WIDTH-1:0]    m_user_q, m_user_d;
  logic [ID_WIDTH-1:0]      m_tid_q, m_tid_d;

  logic [NUM_PORTS-1:0]     req_s;
  logic [NUM_PORTS-1:0]     tready_s;
  logic                     pick_found_s;
  logic [ID_WIDTH-1:0]      pick_s;
  logic                     out_free_s;
  logic                     beat_xfer_s;
  logic [DATA_WIDTH-1:0]    g_data_s;
  logic [KEEP_WIDTH-1:0]    g_keep_s;
  logic                     g_last_s;
  logic [USER_WIDTH-1:0]    g_user_s;

  // Arbitration, per-port ready and output-register load decisions.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_grant_d = cur_grant_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    m_tid_d     = m_tid_q;
    tready_s    = {NUM_PORTS{1'b0}};
    beat_xfer_s = 1'b0;

    req_s                  = s_axis_tvalid & cfg_port_en;
    {pick_found_s, pick_s} = rr_pick(req_s, rr_ptr_q);
    // The output register can take a beat when empty or draining this cycle.
    out_free_s = !m_valid_q || m_axis_tready;

    g_data_s = s_axis_tdata[int'(cur_grant_q) * DATA_WIDTH +: DATA_WIDTH];
    g_keep_s = s_axis_tkeep[int'(cur_grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
    g_user_s = s_axis_tuser[int'(cur_grant_q) * USER_WIDTH +: USER_WIDTH];
    g_last_s = s_axis_tlast[cur_grant_q];

    case (state_q)
      ST_IDLE: begin
        if (!fifo_almost_full && pick_found_s) begin
          state_d     = ST_PKT;
          cur_grant_d = pick_s;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_PKT: begin
        tready_s[cur_grant_q] = out_free_s;
        beat_xfer_s           = out_free_s && s_axis_tvalid[cur_grant_q];
        // A stalled source keeps the grant; only TLAST releases it.
        if (beat_xfer_s && g_last_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_port(cur_grant_q);
        end else begin
          state_d  = ST_PKT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (beat_xfer_s) begin
      m_valid_d = 1'b1;
      m_data_d  = g_data_s;
      m_keep_d  = g_keep_s;
      m_last_d  = g_last_s;
      m_user_d  = g_user_s;
      m_tid_d   = cur_grant_q;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // FSM state, round-robin pointer and registered output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_ZERO;
      cur_grant_q <= ID_ZERO;
      m_valid_q   <= 1'b0;
      m_data_q    <= {DATA_WIDTH{1'b0}};
      m_keep_q    <= {KEEP_WIDTH{1'b0}};
      m_last_q    <= 1'b0;
      m_user_q    <= {USER_WIDTH{1'b0}};
      m_tid_q     <= ID_ZERO;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_grant_q <= cur_grant_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      m_tid_q     <= m_tid_d;
    end
  end

  assign s_axis_tready = tready_s;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tid    = m_tid_q;
  assign busy          = (state_q == ST_PKT);
  assign cur_grant     = cur_grant_q;

`ifdef AXIS_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [NUM_PORTS];
  logic [31:0] pkt_cnt_d [NUM_PORTS];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counter next values; a clear discards this cycle's increments.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
    end
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_d[i] = 32'd0;
      end
      stall_cnt_d = 32'd0;
    end else begin
      if (beat_xfer_s && g_last_s) begin
        pkt_cnt_d[cur_grant_q] = pkt_cnt_q[cur_grant_q] + 32'd1;
      end else begin
        pkt_cnt_d[cur_grant_q] = pkt_cnt_q[cur_grant_q];
      end
      if ((state_q == ST_IDLE) && (req_s != {NUM_PORTS{1'b0}}) && fifo_almost_full) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= 32'd0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flatten per-port counts onto the output bus.
  always_comb begin
    stat_pkt_cnt = {(NUM_PORTS*32){1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      stat_pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_arbiter
//
// Randomised and directed stimulus for axis_pkt_arbiter. A transaction-level
// reference (per-port packet queues, a round-robin pointer and a one-entry
// output slot) predicts ready, valid, busy, grant and payload every cycle; an
// independent scoreboard checks per-port ordering and packet atomicity; a few
// literal sequences pin the reference itself.
// -----------------------------------------------------------------------------
module tb_axis_pkt_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 72;
  localparam int IW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [UW-1:0]   m_tuser;
  logic [IW-1:0]   m_tid;
  logic            m_tvalid;
  logic            m_tready;
  logic            afull;
  logic [N-1:0]    cfg_en;
  logic            busy;
  logic [IW-1:0]   cur_grant;
`ifdef AXIS_ARB_STATS_EN
  logic            stat_clr;
  logic [N*32-1:0] stat_pkt_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tid(m_tid), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .fifo_almost_full(afull), .cfg_port_en(cfg_en),
    .busy(busy),
`ifdef AXIS_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_pkt_cnt(stat_pkt_cnt), .stat_stall_cnt(stat_stall_cnt),
`endif
    .cur_grant(cur_grant)
  );

  // Sources, scoreboard and knobs
  beat_t    src_q[N][$];
  beat_t    sb_q[N][$];
  logic [N-1:0] vld;
  int       vld_prob = 100, rdy_prob = 100, af_prob = 0;
  bit       drive_rnd = 1'b0;
  int       pkt_id = 0;
  int       acc_cnt[N];
  bit       sb_open = 1'b0;
  logic [IW-1:0] sb_tid;

  // Logs for literal expectations
  bit       log_en = 1'b0;
  int       tr_tid[$];
  bit       tr_sv[$];
  int       pk_tid[$];
  bit       hs_last[$];

  // Reference state
  bit       mdl_pkt, mdl_ov;
  int       mdl_port, mdl_ptr, mdl_grant, mdl_otid;
  beat_t    mdl_ob;
  logic [31:0] mdl_pc[N];
  logic [31:0] mdl_stall;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic beat_t mk_beat(input int p, input int pk, input int b, input bit last);
    beat_t r;
    r.d = {8'(p), 16'(pk), 8'(b), 32'($urandom)};
    r.k = 8'($urandom);
    r.l = last;
    r.u = {32'($urandom), 32'($urandom), 8'(p)};
    return r;
  endfunction

  task automatic add_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) src_q[p].push_back(mk_beat(p, pkt_id, b, b == len - 1));
    pkt_id++;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      if (vld[i]) begin
        s_tdata[i*DW +: DW] = src_q[i][0].d;
        s_tkeep[i*KW +: KW] = src_q[i][0].k;
        s_tlast[i]          = src_q[i][0].l;
        s_tuser[i*UW +: UW] = src_q[i][0].u;
      end else begin
        s_tdata[i*DW +: DW] = '0;
        s_tkeep[i*KW +: KW] = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i*UW +: UW] = '0;
      end
    end
    s_tvalid = vld;
  endtask

  function automatic bit all_idle();
    bit e = !mdl_pkt && !mdl_ov;
    for (int i = 0; i < N; i++) e = e && (src_q[i].size() == 0) && (sb_q[i].size() == 0);
    return e;
  endfunction

  task automatic mdl_reset();
    mdl_pkt = 0; mdl_ov = 0; mdl_port = 0; mdl_ptr = 0; mdl_grant = 0; mdl_otid = 0;
    mdl_ob = '0; mdl_stall = 0; sb_open = 0;
    for (int i = 0; i < N; i++) begin mdl_pc[i] = 0; src_q[i].delete(); sb_q[i].delete(); end
    vld = '0;
  endtask

  task automatic clr_log();
    tr_tid.delete(); tr_sv.delete(); pk_tid.delete(); hs_last.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  // One clock: check at negedge, advance reference, then update sources.
  task automatic step();
    logic [N-1:0] exp_rdy, req, hs;
    beat_t bb;
    bit found;
    int p;
    @(negedge clk);
    exp_rdy = '0;
    if (mdl_pkt && (!mdl_ov || m_tready)) exp_rdy[mdl_port] = 1'b1;
    chk("ctrl", {s_tready, m_tvalid, busy, cur_grant},
                {exp_rdy, mdl_ov, mdl_pkt, IW'(mdl_grant)});
    if (mdl_ov) chk("mdata", {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}, {mdl_ob, IW'(mdl_otid)});
`ifdef AXIS_ARB_STATS_EN
    chk("stat_pkt", stat_pkt_cnt, {mdl_pc[3], mdl_pc[2], mdl_pc[1], mdl_pc[0]});
    chk("stat_stall", stat_stall_cnt, mdl_stall);
`endif
    if (m_tvalid && m_tready) begin
      if (sb_q[m_tid].size() == 0) chk("sb_extra", sb_q[m_tid].size(), 1);
      else begin
        bb = sb_q[m_tid].pop_front();
        chk("sb_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, bb);
      end
      if (sb_open) chk("atomic", m_tid, sb_tid);
      else if (log_en) pk_tid.push_back(int'(m_tid));
      sb_open = !m_tlast;
      sb_tid  = m_tid;
      if (log_en) begin tr_tid.push_back(int'(m_tid)); hs_last.push_back(m_tlast); end
    end else if (log_en) tr_tid.push_back(-1);
    if (log_en) tr_sv.push_back(|s_tvalid);

    // Reference advance for the coming edge
    req = s_tvalid & cfg_en;
    if (mdl_pkt) begin
      if (s_tvalid[mdl_port] && exp_rdy[mdl_port]) begin
        bb.d = s_tdata[mdl_port*DW +: DW];
        bb.k = s_tkeep[mdl_port*KW +: KW];
        bb.l = s_tlast[mdl_port];
        bb.u = s_tuser[mdl_port*UW +: UW];
        mdl_ob = bb; mdl_otid = mdl_port; mdl_ov = 1;
        if (bb.l) begin
          mdl_pkt = 0;
          mdl_ptr = (mdl_port + 1) % N;
          mdl_pc[mdl_port] = mdl_pc[mdl_port] + 1;
        end
      end else if (m_tready) mdl_ov = 0;
    end else begin
      if (m_tready) mdl_ov = 0;
      if (req != 0 && afull) mdl_stall = mdl_stall + 1;
      if (!afull && req != 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          p = (mdl_ptr + k) % N;
          if (!found && req[p]) begin found = 1; mdl_pkt = 1; mdl_port = p; mdl_grant = p; end
        end
      end
    end
`ifdef AXIS_ARB_STATS_EN
    if (stat_clr) begin
      for (int i = 0; i < N; i++) mdl_pc[i] = 0;
      mdl_stall = 0;
    end
`endif
    hs = s_tvalid & s_tready;

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        sb_q[i].push_back(src_q[i].pop_front());
        acc_cnt[i]++;
        vld[i] = 1'b0;
      end
      if (!vld[i] && src_q[i].size() > 0 && $urandom_range(99) < vld_prob) vld[i] = 1'b1;
    end
    if (drive_rnd) begin
      m_tready = ($urandom_range(99) < rdy_prob);
      afull    = ($urandom_range(99) < af_prob);
    end
    drive_bus();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}, '0);
    chk("rst_ctl", {s_tready, busy, cur_grant}, '0);
    mdl_reset();
    drive_bus();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int c;
    cfg_en = 4'hF; afull = 1'b0; m_tready = 1'b1; vld_prob = 100; drive_rnd = 1'b0;
    for (c = 0; c < 600 && !all_idle(); c++) step();
    chk(name, all_idle(), 1'b1);
  endtask

  int exp_rr[19] = '{0, 0, 0, -1, 1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3, -1, 0, 0, 0};
  int exp_en[5]  = '{1, 3, 1, 3, 3};
  bit tgl_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int i0, i1, c, nl;
    rst_n = 1'b0; m_tready = 1'b1; afull = 1'b0; cfg_en = 4'hF;
`ifdef AXIS_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    mdl_reset();
    drive_bus();
    #22;
    chk("rst0_out", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}, '0);
    chk("rst0_ctl", {s_tready, busy, cur_grant}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order with continuous valid and ready
    clr_log(); log_en = 1'b1;
    add_pkt(0, 3); add_pkt(1, 3); add_pkt(2, 3); add_pkt(3, 3); add_pkt(0, 3);
    for (c = 0; c < 80 && !all_idle(); c++) step();
    chk("rr_done", all_idle(), 1'b1);
    i0 = -1; i1 = -1;
    for (int k = 0; k < tr_sv.size(); k++) if (i0 < 0 && tr_sv[k]) i0 = k;
    for (int k = 0; k < tr_tid.size(); k++) if (i1 < 0 && tr_tid[k] >= 0) i1 = k;
    chk("latency", i1 - i0, 2);
    chk("rr_len", (i1 >= 0) && (tr_tid.size() >= i1 + 19), 1'b1);
    if ((i1 >= 0) && (tr_tid.size() >= i1 + 19))
      for (int k = 0; k < 19; k++) chk("rr_seq", tr_tid[i1 + k], exp_rr[k]);
    log_en = 1'b0;

    // Reset in the middle of a port-2 packet; pointer must restart at 0
    clr_log();
    add_pkt(2, 5);
    for (c = 0; c < 40 && acc_cnt[2] < 3; c++) step();
    chk("p2_beats", acc_cnt[2], 3);
    do_reset();
    clr_log(); log_en = 1'b1;
    add_pkt(0, 2); add_pkt(3, 2);
    for (c = 0; c < 40 && !all_idle(); c++) step();
    chk("rst_next_n", pk_tid.size(), 2);
    if (pk_tid.size() > 0) chk("rst_next", pk_tid[0], 0);
    log_en = 1'b0;

    // Almost-full blocks new packets but not the one in flight
    do_reset(); clr_log();
    add_pkt(1, 6);
    for (c = 0; c < 20 && !(mdl_pkt && mdl_port == 1); c++) step();
    add_pkt(3, 3);
    afull = 1'b1;
    for (c = 0; c < 30 && mdl_pkt; c++) step();
    chk("af_p1_done", acc_cnt[1], 6);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("af_block", {busy, s_tready[3]}, 2'b00);
      chk("af_grant", cur_grant, 2'd1);
    end
    afull = 1'b0;
    for (c = 1; c <= 5; c++) begin step(); if (s_tready[3]) break; end
    chk("af_resume", c <= 2, 1'b1);
    drain("af_drain");

    // Downstream ready toggling 1,0,0,1 over an 8-beat packet
    do_reset(); clr_log(); log_en = 1'b1;
    add_pkt(0, 8);
    for (c = 0; c < 80 && !all_idle(); c++) begin m_tready = tgl_pat[c % 4]; step(); end
    m_tready = 1'b1;
    chk("tgl_beats", hs_last.size(), 8);
    nl = 0;
    foreach (hs_last[k]) nl += hs_last[k];
    chk("tgl_nlast", nl, 1);
    if (hs_last.size() == 8) chk("tgl_lastpos", hs_last[7], 1'b1);
    log_en = 1'b0;

    // Port enables 1010, then port 1 disabled mid-packet
    do_reset(); clr_log(); log_en = 1'b1;
    cfg_en = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, 2); add_pkt(1, 3); add_pkt(2, 2); add_pkt(3, 3);
    end
    for (c = 0; c < 100 && pk_tid.size() < 3; c++) step();
    cfg_en = 4'b1000;
    for (c = 0; c < 100 && !(src_q[3].size() == 0 && !mdl_pkt && !mdl_ov); c++) step();
    chk("en_npk", pk_tid.size(), 5);
    if (pk_tid.size() == 5) for (int k = 0; k < 5; k++) chk("en_seq", pk_tid[k], exp_en[k]);
    chk("en_p1_left", src_q[1].size(), 3);
    log_en = 1'b0;
    drain("en_drain");

    // Randomised traffic
    do_reset();
    drive_rnd = 1'b1; rdy_prob = 70; af_prob = 20; vld_prob = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int p;
      if ($urandom_range(99) < 20) begin
        p = $urandom_range(N - 1);
        if (src_q[p].size() < 12) add_pkt(p, $urandom_range(6, 1));
      end
      if (cyc % 150 == 0) cfg_en = 4'($urandom);
      step();
    end
    drain("rnd_drain");

`ifdef AXIS_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) add_pkt(0, 2);
    add_pkt(3, 1); add_pkt(3, 3);
    drain("st_drain");
    step();
    chk("st_cnt", stat_pkt_cnt, {32'd2, 32'd0, 32'd0, 32'd5});
    stat_clr = 1'b1; step(); stat_clr = 1'b0; step();
    chk("st_clr", {stat_pkt_cnt, stat_stall_cnt}, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
